// File: rtl/mem_bus_arbiter_if.sv
// Request/grant handshake for the two requesters plus the memory strobes and address
// of the shared single-port memory. The tri-state data bus stays a plain inout port.
interface mem_bus_arbiter_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);
  logic              i_req0;
  logic              i_we0;
  logic [ADDR_W-1:0] i_addr0;
  logic [DATA_W-1:0] i_wdata0;
  logic              o_gnt0;
  logic              o_done0;

  logic              i_req1;
  logic              i_we1;
  logic [ADDR_W-1:0] i_addr1;
  logic [DATA_W-1:0] i_wdata1;
  logic              o_gnt1;
  logic              o_done1;

  logic [DATA_W-1:0] o_rdata;
  logic              o_mem_read_n;
  logic              o_mem_write_n;
  logic [ADDR_W-1:0] o_mem_addr;

  modport master (
    output i_req0, i_we0, i_addr0, i_wdata0,
    output i_req1, i_we1, i_addr1, i_wdata1,
    input  o_gnt0, o_done0, o_gnt1, o_done1,
    input  o_rdata, o_mem_read_n, o_mem_write_n, o_mem_addr
  );

  modport slave (
    input  i_req0, i_we0, i_addr0, i_wdata0,
    input  i_req1, i_we1, i_addr1, i_wdata1,
    output o_gnt0, o_done0, o_gnt1, o_done1,
    output o_rdata, o_mem_read_n, o_mem_write_n, o_mem_addr
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-requester arbiter for a single-port memory: IDLE -> ACCESS -> DONE sequencing,
// active-low strobes, tri-state write drive and registered read capture.
module mem_bus_arbiter #(
  parameter int ADDR_W     = 4,
  parameter int DATA_W     = 8,
  parameter int FIXED_PRIO = 0
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  mem_bus_arbiter_if.slave   bus,
  inout  wire  [DATA_W-1:0]  io_bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t            state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_owner_q, last_owner_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [1:0]        gnt_q, gnt_d;
  logic [1:0]        done_q, done_d;
  logic              read_n_q, read_n_d;
  logic              write_n_q, write_n_d;
  logic              drive_q, drive_d;

  logic [1:0]        req;
  logic              pick1;

  assign req = {bus.i_req1, bus.i_req0};

  // On a tie, round-robin hands the memory to whoever did not own it last.
  always_comb begin
    pick1 = req[1];
    if (req == 2'b11) begin
      pick1 = (FIXED_PRIO == 0) && !last_owner_q;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    gnt_d        = gnt_q;
    done_d       = 2'b00;
    read_n_d     = 1'b1;
    write_n_d    = 1'b1;
    drive_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req) begin
          owner_d   = pick1;
          we_d      = pick1 ? bus.i_we1    : bus.i_we0;
          addr_d    = pick1 ? bus.i_addr1  : bus.i_addr0;
          wdata_d   = pick1 ? bus.i_wdata1 : bus.i_wdata0;
          gnt_d     = pick1 ? 2'b10 : 2'b01;
          read_n_d  = we_d;
          write_n_d = !we_d;
          drive_d   = we_d;
          state_d   = ACCESS;
        end
      end
      ACCESS: begin
        if (!we_q) begin
          rdata_d = io_bus;
        end
        done_d       = gnt_q;
        last_owner_d = owner_q;
        state_d      = DONE;
      end
      DONE: begin
        gnt_d   = 2'b00;
        state_d = IDLE;
      end
      default: begin
        gnt_d   = 2'b00;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      gnt_q        <= 2'b00;
      done_q       <= 2'b00;
      read_n_q     <= 1'b1;
      write_n_q    <= 1'b1;
      drive_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      gnt_q        <= gnt_d;
      done_q       <= done_d;
      read_n_q     <= read_n_d;
      write_n_q    <= write_n_d;
      drive_q      <= drive_d;
    end
  end

  assign bus.o_gnt0        = gnt_q[0];
  assign bus.o_gnt1        = gnt_q[1];
  assign bus.o_done0       = done_q[0];
  assign bus.o_done1       = done_q[1];
  assign bus.o_rdata       = rdata_q;
  assign bus.o_mem_read_n  = read_n_q;
  assign bus.o_mem_write_n = write_n_q;
  assign bus.o_mem_addr    = addr_q;
  assign io_bus            = drive_q ? wdata_q : {DATA_W{1'bz}};

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Randomized self-checking bench: a transaction-level memory/arbitration model predicts
// owners, read data and done timing for a round-robin and a fixed-priority instance.
`timescale 1ns/1ps
module tb_mem_bus_arbiter;
  localparam int AW = 4;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit mon_en   = 1'b0;
  always @(posedge clk) cyc <= cyc + 1;

  mem_bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus0 ();
  mem_bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus1 ();
  tri0 [DW-1:0] io_bus0;
  tri0 [DW-1:0] io_bus1;

  mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIXED_PRIO(0)) dut_rr (
    .i_clk(clk), .i_reset_n(rst_n), .bus(bus0.slave), .io_bus(io_bus0));
  mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIXED_PRIO(1)) dut_fp (
    .i_clk(clk), .i_reset_n(rst_n), .bus(bus1.slave), .io_bus(io_bus1));

  // memory environment for the round-robin instance (preload port + strobe-driven access)
  logic [DW-1:0] mem0 [16];
  logic          pl_en = 1'b0;
  logic [AW-1:0] pl_addr = '0;
  logic [DW-1:0] pl_data = '0;
  assign io_bus0 = !bus0.o_mem_read_n ? mem0[bus0.o_mem_addr] : 'z;
  always @(posedge clk) begin
    if (pl_en) mem0[pl_addr] <= pl_data;
    else if (!bus0.o_mem_write_n) mem0[bus0.o_mem_addr] <= io_bus0;
  end
  // fixed-priority instance reads back a value derived from its address
  assign io_bus1 = !bus1.o_mem_read_n ? {4'h0, bus1.o_mem_addr} : 'z;

  // reference model state
  logic [DW-1:0] ref_mem [16];
  logic [DW-1:0] last_rd;

  typedef struct {bit own; bit we; logic [AW-1:0] a; logic [DW-1:0] d; int c;} acc_t;
  typedef struct {bit own; logic [DW-1:0] rd; int c;} done_t;
  acc_t  acc_q[$];
  done_t done_q0[$];
  done_t done_q1[$];

  always @(negedge clk) begin
    if (mon_en) begin
      n_checks++;
      if (!bus0.o_mem_read_n && !bus0.o_mem_write_n) begin
        n_fail++; $display("FAIL strobes_both_low cyc=%0d read_n=%b write_n=%b required not both 0", cyc, bus0.o_mem_read_n, bus0.o_mem_write_n);
      end
      n_checks++;
      if ((bus0.o_gnt0 && bus0.o_gnt1) || (bus1.o_gnt0 && bus1.o_gnt1)) begin
        n_fail++; $display("FAIL gnt_both cyc=%0d rr=%b%b fp=%b%b required not both 1", cyc, bus0.o_gnt0, bus0.o_gnt1, bus1.o_gnt0, bus1.o_gnt1);
      end
      n_checks++;
      if (bus0.o_mem_read_n && bus0.o_mem_write_n && io_bus0 !== '0) begin
        n_fail++; $display("FAIL bus_released cyc=%0d io_bus=%h required undriven", cyc, io_bus0);
      end
      if (!bus0.o_mem_read_n || !bus0.o_mem_write_n)
        acc_q.push_back('{bus0.o_gnt1, !bus0.o_mem_write_n, bus0.o_mem_addr, io_bus0, cyc});
      if (bus0.o_done0) done_q0.push_back('{1'b0, bus0.o_rdata, cyc});
      if (bus0.o_done1) done_q0.push_back('{1'b1, bus0.o_rdata, cyc});
      if (bus1.o_done0) done_q1.push_back('{1'b0, bus1.o_rdata, cyc});
      if (bus1.o_done1) done_q1.push_back('{1'b1, bus1.o_rdata, cyc});
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    last_rd = '0;
  endtask

  task automatic preload();
    for (int i = 0; i < 16; i++) begin
      pl_en = 1'b1;
      pl_addr = AW'(i);
      pl_data = (i == 13) ? 8'h3F : DW'($urandom);
      ref_mem[i] = pl_data;
      @(negedge clk);
    end
    pl_en = 1'b0;
    @(negedge clk);
  endtask

  // Issues one request on the RR instance, scrambles its inputs once latched, drops on done.
  task automatic drive_single(input bit p, input bit we, input logic [AW-1:0] a,
                              input logic [DW-1:0] d, output int lat, output bit tmo);
    int  t0;
    bit  seen;
    seen = 1'b0;
    lat  = -1;
    if (p) begin bus0.i_req1 = 1'b1; bus0.i_we1 = we; bus0.i_addr1 = a; bus0.i_wdata1 = d; end
    else   begin bus0.i_req0 = 1'b1; bus0.i_we0 = we; bus0.i_addr0 = a; bus0.i_wdata0 = d; end
    t0 = cyc;
    @(posedge clk); #1;
    if (p) begin bus0.i_we1 = ~we; bus0.i_addr1 = ~a; bus0.i_wdata1 = ~d; end
    else   begin bus0.i_we0 = ~we; bus0.i_addr0 = ~a; bus0.i_wdata0 = ~d; end
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if ((p && bus0.o_done1) || (!p && bus0.o_done0)) begin
        seen = 1'b1;
        lat  = cyc - t0;
      end
    end
    bus0.i_req0 = 1'b0;
    bus0.i_req1 = 1'b0;
    tmo = !seen;
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    mon_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_checks++;
      if (bus0.o_mem_read_n !== 1'b1 || bus0.o_mem_write_n !== 1'b1) begin
        n_fail++; $display("FAIL reset_strobes cyc=%0d got=%b%b required 11", cyc, bus0.o_mem_read_n, bus0.o_mem_write_n);
      end
      n_checks++;
      if ({bus0.o_gnt0, bus0.o_gnt1, bus0.o_done0, bus0.o_done1} !== 4'b0000) begin
        n_fail++; $display("FAIL reset_gnt_done cyc=%0d got=%b%b%b%b required 0000", cyc, bus0.o_gnt0, bus0.o_gnt1, bus0.o_done0, bus0.o_done1);
      end
      n_checks++;
      if (bus0.o_rdata !== 8'h00 || bus0.o_mem_addr !== 4'h0) begin
        n_fail++; $display("FAIL reset_rdata_addr cyc=%0d rdata=%h addr=%h required 00/0", cyc, bus0.o_rdata, bus0.o_mem_addr);
      end
    end
  endtask

  task automatic test_read();
    int lat; bit tmo;
    acc_q.delete(); done_q0.delete();
    drive_single(1'b0, 1'b0, 4'd13, 8'h00, lat, tmo);
    n_checks++;
    if (tmo || lat != 2) begin
      n_fail++; $display("FAIL read13_latency got=%0d timeout=%b required 2", lat, tmo);
    end
    n_checks++;
    if (acc_q.size() != 1 || acc_q[0].we || acc_q[0].own || acc_q[0].a != 4'd13) begin
      n_fail++; $display("FAIL read13_strobe got cycles=%0d required 1 read strobe at addr 13 by req0", acc_q.size());
    end
    n_checks++;
    if (bus0.o_rdata !== 8'h3F) begin
      n_fail++; $display("FAIL read13_rdata got=%h required 3f", bus0.o_rdata);
    end
    last_rd = 8'h3F;
  endtask

  task automatic test_write_read();
    int lat; bit tmo;
    acc_q.delete(); done_q0.delete();
    drive_single(1'b1, 1'b1, 4'd5, 8'hA5, lat, tmo);
    ref_mem[5] = 8'hA5;
    n_checks++;
    if (tmo || lat != 2) begin
      n_fail++; $display("FAIL wr5_latency got=%0d timeout=%b required 2", lat, tmo);
    end
    n_checks++;
    if (acc_q.size() != 1 || !acc_q[0].we || !acc_q[0].own || acc_q[0].a != 4'd5 || acc_q[0].d !== 8'hA5) begin
      n_fail++; $display("FAIL wr5_strobe got cycles=%0d data=%h required 1 write strobe data a5", acc_q.size(), (acc_q.size() > 0) ? acc_q[0].d : 8'hxx);
    end
    n_checks++;
    if (bus0.o_rdata !== last_rd) begin
      n_fail++; $display("FAIL wr5_rdata_hold got=%h required %h", bus0.o_rdata, last_rd);
    end
    drive_single(1'b0, 1'b0, 4'd5, 8'h00, lat, tmo);
    last_rd = ref_mem[5];
    n_checks++;
    if (tmo || bus0.o_rdata !== 8'hA5) begin
      n_fail++; $display("FAIL rd5_rdata got=%h timeout=%b required a5", bus0.o_rdata, tmo);
    end
  endtask

  task automatic test_random();
    int lat; bit tmo; bit p; bit we;
    logic [AW-1:0] a; logic [DW-1:0] d; logic [DW-1:0] exp_rd; logic [DW-1:0] exp_bus;
    for (int it = 0; it < 24; it++) begin
      p  = 1'($urandom_range(0, 1));
      we = 1'($urandom_range(0, 1));
      a  = AW'($urandom_range(0, 15));
      d  = DW'($urandom);
      exp_bus = we ? d : ref_mem[a];
      exp_rd  = we ? last_rd : ref_mem[a];
      acc_q.delete(); done_q0.delete();
      drive_single(p, we, a, d, lat, tmo);
      if (we) ref_mem[a] = d;
      last_rd = exp_rd;
      n_checks++;
      if (tmo || lat != 2) begin
        n_fail++; $display("FAIL rand%0d_latency got=%0d timeout=%b required 2", it, lat, tmo);
      end
      n_checks++;
      if (acc_q.size() != 1 || acc_q[0].own != p || acc_q[0].we != we || acc_q[0].a != a || acc_q[0].d !== exp_bus) begin
        n_fail++; $display("FAIL rand%0d_access got cycles=%0d required 1 (own=%b we=%b addr=%h data=%h)", it, acc_q.size(), p, we, a, exp_bus);
      end
      n_checks++;
      if (done_q0.size() != 1 || done_q0[0].own != p || bus0.o_rdata !== exp_rd) begin
        n_fail++; $display("FAIL rand%0d_done got dones=%0d rdata=%h required 1 done own=%b rdata=%h", it, done_q0.size(), bus0.o_rdata, p, exp_rd);
      end
    end
  endtask

  task automatic test_back_to_back();
    bit last; bit exp_own; logic [DW-1:0] exp;
    do_reset();
    @(negedge clk);
    done_q0.delete();
    last = 1'b1;
    bus0.i_req0 = 1'b1; bus0.i_we0 = 1'b0; bus0.i_addr0 = 4'd2;
    bus0.i_req1 = 1'b1; bus0.i_we1 = 1'b0; bus0.i_addr1 = 4'd9;
    for (int i = 0; i < 40 && done_q0.size() < 6; i++) begin
      @(negedge clk); #1;
    end
    bus0.i_req0 = 1'b0; bus0.i_req1 = 1'b0;
    repeat (4) @(negedge clk);
    n_checks++;
    if (done_q0.size() != 6) begin
      n_fail++; $display("FAIL rr_done_count got=%0d required 6", done_q0.size());
    end
    for (int i = 0; i < 6 && i < done_q0.size(); i++) begin
      exp_own = !last;
      last = exp_own;
      exp = exp_own ? ref_mem[9] : ref_mem[2];
      n_checks++;
      if (done_q0[i].own != exp_own || done_q0[i].rd !== exp) begin
        n_fail++; $display("FAIL rr_grant%0d got own=%b rdata=%h required own=%b rdata=%h", i, done_q0[i].own, done_q0[i].rd, exp_own, exp);
      end
      if (i > 0) begin
        n_checks++;
        if (done_q0[i].c - done_q0[i-1].c != 3) begin
          n_fail++; $display("FAIL rr_period%0d got=%0d required 3", i, done_q0[i].c - done_q0[i-1].c);
        end
      end
    end
    last_rd = ref_mem[9];
  endtask

  task automatic test_fixed_prio();
    bit exp_own; logic [DW-1:0] exp;
    done_q1.delete();
    bus1.i_req0 = 1'b1; bus1.i_we0 = 1'b0; bus1.i_addr0 = 4'h6;
    bus1.i_req1 = 1'b1; bus1.i_we1 = 1'b0; bus1.i_addr1 = 4'hB;
    for (int i = 0; i < 40 && done_q1.size() < 4; i++) begin
      @(negedge clk); #1;
    end
    bus1.i_req0 = 1'b0;
    for (int i = 0; i < 20 && done_q1.size() < 5; i++) begin
      @(negedge clk); #1;
    end
    bus1.i_req1 = 1'b0;
    repeat (4) @(negedge clk);
    n_checks++;
    if (done_q1.size() != 5) begin
      n_fail++; $display("FAIL fp_done_count got=%0d required 5", done_q1.size());
    end
    for (int i = 0; i < 5 && i < done_q1.size(); i++) begin
      exp_own = (i >= 4);
      exp = exp_own ? 8'h0B : 8'h06;
      n_checks++;
      if (done_q1[i].own != exp_own || done_q1[i].rd !== exp) begin
        n_fail++; $display("FAIL fp_grant%0d got own=%b rdata=%h required own=%b rdata=%h", i, done_q1[i].own, done_q1[i].rd, exp_own, exp);
      end
      if (i > 0) begin
        n_checks++;
        if (done_q1[i].c - done_q1[i-1].c != 3) begin
          n_fail++; $display("FAIL fp_period%0d got=%0d required 3", i, done_q1[i].c - done_q1[i-1].c);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int lat; bit tmo;
    done_q0.delete();
    bus0.i_req1 = 1'b1; bus0.i_we1 = 1'b1; bus0.i_addr1 = 4'd7; bus0.i_wdata1 = 8'hC3;
    @(posedge clk); #1;
    n_checks++;
    if (bus0.o_mem_write_n !== 1'b0) begin
      n_fail++; $display("FAIL abort_in_access got write_n=%b required 0", bus0.o_mem_write_n);
    end
    rst_n = 1'b0;
    ref_mem[7] = 8'hC3;
    @(posedge clk); #1;
    n_checks++;
    if (bus0.o_mem_write_n !== 1'b1 || bus0.o_mem_read_n !== 1'b1 || io_bus0 !== '0) begin
      n_fail++; $display("FAIL abort_strobes got=%b%b bus=%h required 11 undriven", bus0.o_mem_read_n, bus0.o_mem_write_n, io_bus0);
    end
    n_checks++;
    if (bus0.o_gnt1 !== 1'b0 || bus0.o_done1 !== 1'b0 || bus0.o_rdata !== 8'h00) begin
      n_fail++; $display("FAIL abort_outputs got gnt1=%b done1=%b rdata=%h required 0 0 00", bus0.o_gnt1, bus0.o_done1, bus0.o_rdata);
    end
    bus0.i_req1 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    last_rd = '0;
    repeat (4) @(negedge clk);
    n_checks++;
    if (done_q0.size() != 0) begin
      n_fail++; $display("FAIL abort_no_done got=%0d dones required 0", done_q0.size());
    end
    drive_single(1'b0, 1'b0, 4'd3, 8'h00, lat, tmo);
    n_checks++;
    if (tmo || lat != 2 || bus0.o_rdata !== ref_mem[3]) begin
      n_fail++; $display("FAIL abort_then_read got lat=%0d rdata=%h required 2 %h", lat, bus0.o_rdata, ref_mem[3]);
    end
  endtask

  initial begin
    bus0.i_req0 = 1'b0; bus0.i_we0 = 1'b0; bus0.i_addr0 = '0; bus0.i_wdata0 = '0;
    bus0.i_req1 = 1'b0; bus0.i_we1 = 1'b0; bus0.i_addr1 = '0; bus0.i_wdata1 = '0;
    bus1.i_req0 = 1'b0; bus1.i_we0 = 1'b0; bus1.i_addr0 = '0; bus1.i_wdata0 = '0;
    bus1.i_req1 = 1'b0; bus1.i_we1 = 1'b0; bus1.i_addr1 = '0; bus1.i_wdata1 = '0;
    last_rd = '0;
    @(negedge clk);
    test_reset();
    preload();
    test_read();
    test_write_read();
    test_random();
    test_back_to_back();
    test_fixed_prio();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
